pll_speed_ctrl: RTL and testbench

- Sequences run-time reconfiguration of the system PLL's CPU-clock output counter through the PLL reconfiguration IP's Avalon-MM management port.
- Switches the CPU clock between turbo profiles: 4.77, 7.16, 9.54 MHz and one spare.
- Holds the CPU clock-domain reset during the switch and releases it only after the PLL re-locks.
- Sits between the OSD/turbo-select logic and the PLL reconfig IP.

---
 rtl/pll_speed_pkg.sv | 35 +++
 rtl/avmm_master_if.sv | 72 +++++++
 rtl/pll_speed_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_speed_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_speed_pkg.sv
// rtl/pll_speed_pkg.sv - register map, FSM states and C-counter profile table
// for the PLL CPU-clock speed controller.
package pll_speed_pkg;

    localparam logic [5:0] REG_MODE   = 6'd0;
    localparam logic [5:0] REG_STATUS = 6'd1;
    localparam logic [5:0] REG_START  = 6'd2;
    localparam logic [5:0] REG_C      = 6'd5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MODE_WR,
        ST_CNT_WR,
        ST_START_WR,
        ST_POLL,
        ST_CHK,
        ST_LOCK_WAIT,
        ST_SETTLE,
        ST_FINISH
    } state_e;

    // {odd, bypass, high[7:0], low[7:0]} dividing a 286.36 MHz VCO:
    // /60 = 4.77, /40 = 7.16, /30 = 9.54, /25 spare (odd split 13/12).
    localparam logic [17:0] PROFILE_C [4] = '{
        18'h01E1E,
        18'h01414,
        18'h00F0F,
        18'h20D0C
    };

    function automatic logic [31:0] c_word(input logic [4:0] idx, input logic [1:0] prof);
        return {9'b0, idx, PROFILE_C[prof]};
    endfunction

endpackage

// File: rtl/avmm_master_if.sv
// rtl/avmm_master_if.sv - single-outstanding Avalon-MM master; holds address,
// data and strobe until waitrequest drops, then pulses rsp_valid_o.
module avmm_master_if (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid_i,
    input  logic        cmd_rd_i,
    input  logic [5:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [5:0]  mgmt_address_o,
    output logic        mgmt_write_o,
    output logic        mgmt_read_o,
    output logic [31:0] mgmt_writedata_o,
    input  logic [31:0] mgmt_readdata_i,
    input  logic        mgmt_waitrequest_i
);

    logic [5:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        rsp_q, rsp_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        rsp_d   = 1'b0;
        rdata_d = rdata_q;
        if ((wr_q || rd_q) && !mgmt_waitrequest_i) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            rsp_d = 1'b1;
            if (rd_q) rdata_d = mgmt_readdata_i;
        end else if (!wr_q && !rd_q && cmd_valid_i) begin
            addr_d = cmd_addr_i;
            data_d = cmd_data_i;
            wr_d   = !cmd_rd_i;
            rd_d   = cmd_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rsp_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
        end
    end

    assign mgmt_address_o   = addr_q;
    assign mgmt_writedata_o = data_q;
    assign mgmt_write_o     = wr_q;
    assign mgmt_read_o      = rd_q;
    assign rsp_valid_o      = rsp_q;
    assign rsp_rdata_o      = rdata_q;

endmodule

// File: rtl/pll_speed_ctrl.sv
// rtl/pll_speed_ctrl.sv - sequences PLL C-counter reconfiguration for CPU turbo
// profiles, holding the CPU-domain reset until the PLL re-locks and settles.
module pll_speed_ctrl
    import pll_speed_pkg::*;
#(
    parameter int unsigned C_COUNTER_IDX = 2,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RESET_SEL     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  sel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  cur_sel,
    output logic        dom_reset,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       tgt_q, tgt_d, cur_sel_q, cur_sel_d, pend_sel_q, pend_sel_d;
    logic             pend_v_q, pend_v_d, busy_q, busy_d, done_q, done_d;
    logic             error_q, error_d, dom_reset_q, dom_reset_d, issued_q, issued_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [STL_W-1:0] settle_q, settle_d;
    logic             lock_meta_q, lock_q;

    logic             cmd_valid, cmd_rd, rsp_valid;
    logic [5:0]       cmd_addr;
    logic [31:0]      cmd_data, rsp_rdata;
    logic             nxt_v, tmo_hit;
    logic [1:0]       nxt_sel;
    logic             unused_rdata;

    assign unused_rdata = ^rsp_rdata[31:1];

    avmm_master_if u_avmm (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid_i        (cmd_valid),
        .cmd_rd_i           (cmd_rd),
        .cmd_addr_i         (cmd_addr),
        .cmd_data_i         (cmd_data),
        .rsp_valid_o        (rsp_valid),
        .rsp_rdata_o        (rsp_rdata),
        .mgmt_address_o     (mgmt_address),
        .mgmt_write_o       (mgmt_write),
        .mgmt_read_o        (mgmt_read),
        .mgmt_writedata_o   (mgmt_writedata),
        .mgmt_readdata_i    (mgmt_readdata),
        .mgmt_waitrequest_i (mgmt_waitrequest)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cur_sel_d   = cur_sel_q;
        pend_v_d    = pend_v_q;
        pend_sel_d  = pend_sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        dom_reset_d = dom_reset_q;
        tmo_d       = tmo_q;
        settle_d    = settle_q;
        cmd_valid   = 1'b0;
        cmd_rd      = 1'b0;
        cmd_addr    = REG_MODE;
        cmd_data    = '0;
        nxt_v       = pend_v_q | req;
        nxt_sel     = req ? sel : pend_sel_q;
        tmo_hit     = (tmo_q == TMO_MAX);

        if ((state_q inside {ST_POLL, ST_CHK, ST_LOCK_WAIT}) && !tmo_hit)
            tmo_d = tmo_q + 1'b1;
        if (req && state_q != ST_IDLE) begin
            pend_v_d   = 1'b1;
            pend_sel_d = sel;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    error_d = 1'b0;
                    if (sel == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = sel;
                        busy_d  = 1'b1;
                        state_d = ST_MODE_WR;
                    end
                end
            end
            ST_MODE_WR: begin
                cmd_valid = !issued_q;
                cmd_addr  = REG_MODE;
                cmd_data  = 32'd1;
                if (rsp_valid) state_d = ST_CNT_WR;
            end
            ST_CNT_WR: begin
                cmd_valid = !issued_q;
                cmd_addr  = REG_C;
                cmd_data  = c_word(5'(C_COUNTER_IDX), tgt_q);
                if (rsp_valid) begin
                    dom_reset_d = 1'b1;
                    state_d     = ST_START_WR;
                end
            end
            ST_START_WR: begin
                cmd_valid = !issued_q;
                cmd_addr  = REG_START;
                if (rsp_valid) begin
                    tmo_d   = '0;
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                // The timeout is only honoured between reads so a transfer is never abandoned.
                if (!issued_q && tmo_hit) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cmd_valid = !issued_q;
                    cmd_rd    = 1'b1;
                    cmd_addr  = REG_STATUS;
                    if (rsp_valid) state_d = ST_CHK;
                end
            end
            ST_CHK: state_d = rsp_rdata[0] ? ST_LOCK_WAIT : ST_POLL;
            ST_LOCK_WAIT: begin
                if (lock_q) begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else if (tmo_hit) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_SETTLE: begin
                if (settle_q == STL_LAST) begin
                    cur_sel_d = tgt_q;
                    state_d   = ST_FINISH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_FINISH: begin
                dom_reset_d = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                pend_v_d    = 1'b0;
                state_d     = ST_IDLE;
                if (nxt_v && nxt_sel != cur_sel_q) begin
                    tgt_d   = nxt_sel;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    state_d = ST_MODE_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        issued_d = rsp_valid ? 1'b0 : (issued_q | cmd_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            cur_sel_q   <= 2'(RESET_SEL);
            pend_v_q    <= 1'b0;
            pend_sel_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            dom_reset_q <= 1'b0;
            issued_q    <= 1'b0;
            tmo_q       <= '0;
            settle_q    <= '0;
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cur_sel_q   <= cur_sel_d;
            pend_v_q    <= pend_v_d;
            pend_sel_q  <= pend_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            dom_reset_q <= dom_reset_d;
            issued_q    <= issued_d;
            tmo_q       <= tmo_d;
            settle_q    <= settle_d;
            lock_meta_q <= pll_locked;
            lock_q      <= lock_meta_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cur_sel   = cur_sel_q;
    assign dom_reset = dom_reset_q;

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// tb/tb_pll_speed_ctrl.sv - scoreboard bench: stimulus queues expected bus
// transfers and done results; a negedge monitor pops and compares them.
module tb_pll_speed_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        busy, done, error, dom_reset;
    logic [1:0]  cur_sel;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = 32'd0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;

    always #5 clk = ~clk;

    pll_speed_ctrl #(
        .C_COUNTER_IDX(2), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(16), .RESET_SEL(0)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .sel(sel),
        .busy(busy), .done(done), .error(error), .cur_sel(cur_sel), .dom_reset(dom_reset),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    typedef struct { logic rd; logic [5:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [1:0] cur; logic err; logic bsy; } done_t;
    bus_t  bus_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int reads_done = 0;
    int poll_target = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    logic rd_fire = 1'b0;
    logic prev_stall = 1'b0;
    logic [39:0] prev_bus = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-computed C-counter words with C_COUNTER_IDX=2 in bits [22:18].
    function automatic logic [31:0] exp_cword(input logic [1:0] s);
        case (s)
            2'd0:    return 32'h0008_1E1E;
            2'd1:    return 32'h0008_1414;
            2'd2:    return 32'h0008_0F0F;
            default: return 32'h000A_0D0C;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input logic [1:0] s);
        bus_q.push_back('{rd: 1'b0, addr: 6'd0, data: 32'd1});
        bus_q.push_back('{rd: 1'b0, addr: 6'd5, data: exp_cword(s)});
        bus_q.push_back('{rd: 1'b0, addr: 6'd2, data: 32'd0});
    endtask

    task automatic push_reads(input int zeros);
        for (int i = 0; i <= zeros; i++) bus_q.push_back('{rd: 1'b1, addr: 6'd1, data: 32'd0});
    endtask

    task automatic start_req(input logic [1:0] s, input int zeros);
        poll_target = reads_done + zeros;
        pll_locked = 1'b0;
        req = 1'b1;
        sel = s;
        tick();
        req = 1'b0;
    endtask

    task automatic lock_and_settle();
        int n;
        n = 0;
        while (reads_done < poll_target + 1 && n < 500) begin tick(); n++; end
        chk("poll_reached_ready", 64'(reads_done >= poll_target + 1), 1);
        repeat (10) tick();
        chk("dom_reset_held", dom_reset, 1);
        pll_locked = 1'b1;
        n = 0;
        while (dom_reset && n < 100) begin tick(); n++; end
        // 2 sync flops + lock detect + 16 settle + finish
        chk("dom_reset_release_cycles", n, 20);
    endtask

    // Avalon slave model: programmable wait states, status bit set after poll_target reads.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_fire && !reset) reads_done++;
            #1;
            if (mgmt_write || mgmt_read) begin
                if (stall_cnt < stall_n) begin
                    mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
            end else begin
                mgmt_waitrequest = (stall_n != 0);
                stall_cnt = 0;
            end
            mgmt_readdata = {31'd0, reads_done >= poll_target};
            rd_fire = mgmt_read && !mgmt_waitrequest;
        end
    end

    initial begin
        bus_t  eb;
        done_t ed;
        forever begin
            @(negedge clk);
            if (prev_stall)
                chk("hold_during_wait", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, prev_bus);
            prev_stall = (mgmt_write || mgmt_read) && mgmt_waitrequest && !reset;
            prev_bus = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
            if ((mgmt_write || mgmt_read) && !mgmt_waitrequest && !reset) begin
                if (bus_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_transfer: got addr %0d wr %0b, expected none", mgmt_address, mgmt_write);
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_read", mgmt_read, eb.rd);
                    chk("bus_write", mgmt_write, !eb.rd);
                    chk("bus_addr", mgmt_address, eb.addr);
                    if (!eb.rd) chk("bus_wdata", mgmt_writedata, eb.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    ed = done_q.pop_front();
                    chk("done_cur_sel", cur_sel, ed.cur);
                    chk("done_error", error, ed.err);
                    chk("done_busy", busy, ed.bsy);
                    chk("done_dom_reset", dom_reset, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic any_strobe;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_dom_reset", dom_reset, 0);
        chk("rst_write", mgmt_write, 0);
        chk("rst_read", mgmt_read, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_wdata", mgmt_writedata, 0);
        reset = 1'b0;
        tick();

        // Basic switch 0 -> 2, two not-ready polls.
        push_writes(2'd2); push_reads(2);
        done_q.push_back('{cur: 2'd2, err: 1'b0, bsy: 1'b0});
        start_req(2'd2, 2);
        chk("busy_after_req", busy, 1);
        lock_and_settle();
        repeat (3) tick();

        // Five wait states on every transfer, 2 -> 1.
        stall_n = 5;
        push_writes(2'd1); push_reads(1);
        done_q.push_back('{cur: 2'd1, err: 1'b0, bsy: 1'b0});
        start_req(2'd1, 1);
        lock_and_settle();
        stall_n = 0;
        repeat (3) tick();

        // Same profile: immediate done, no bus traffic.
        done_q.push_back('{cur: 2'd1, err: 1'b0, bsy: 1'b0});
        start_req(2'd1, 0);
        chk("same_sel_done_next_cycle", done, 1);
        any_strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); any_strobe |= mgmt_write | mgmt_read; end
        chk("same_sel_no_bus", any_strobe, 0);

        // Lock never returns: timeout, error, cur_sel unchanged.
        push_writes(2'd0); push_reads(0);
        done_q.push_back('{cur: 2'd1, err: 1'b1, bsy: 1'b0});
        start_req(2'd0, 0);
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        chk("timeout_done_window", 64'(n >= 100 && n <= 120), 1);
        repeat (5) tick();
        chk("timeout_error_sticky", error, 1);
        chk("timeout_dom_reset_low", dom_reset, 0);
        chk("timeout_cur_sel", cur_sel, 1);

        // Next successful request clears error.
        push_writes(2'd0); push_reads(0);
        done_q.push_back('{cur: 2'd0, err: 1'b0, bsy: 1'b0});
        start_req(2'd0, 0);
        chk("error_cleared_on_accept", error, 0);
        lock_and_settle();
        repeat (3) tick();

        // Pending: sel=1 then sel=3 while busy on 2; only 3 runs afterwards.
        push_writes(2'd2); push_reads(0);
        done_q.push_back('{cur: 2'd2, err: 1'b0, bsy: 1'b1});
        push_writes(2'd3); push_reads(0);
        done_q.push_back('{cur: 2'd3, err: 1'b0, bsy: 1'b0});
        start_req(2'd2, 0);
        repeat (3) tick();
        req = 1'b1; sel = 2'd1; tick();
        req = 1'b0; tick();
        req = 1'b1; sel = 2'd3; tick();
        req = 1'b0;
        lock_and_settle();
        pll_locked = 1'b0;
        poll_target = reads_done;
        lock_and_settle();
        repeat (3) tick();
        chk("pending_final_cur_sel", cur_sel, 3);
        chk("pending_final_busy", busy, 0);

        // Reset while a status read is stalled.
        stall_n = 5;
        push_writes(2'd0);
        start_req(2'd0, 0);
        n = 0;
        while (!mgmt_read && n < 200) begin tick(); n++; end
        chk("reached_poll", mgmt_read, 1);
        reset = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_cur_sel", cur_sel, 0);
        chk("midrst_dom_reset", dom_reset, 0);
        chk("midrst_strobes", {mgmt_write, mgmt_read}, 0);
        chk("midrst_addr_data", {mgmt_address, mgmt_writedata}, 0);
        reset = 1'b0;
        stall_n = 0;
        any_strobe = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); any_strobe |= mgmt_write | mgmt_read; end
        chk("midrst_no_bus", any_strobe, 0);

        chk("bus_queue_drained", bus_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
